// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter, timed by a 16x oversampled baud tick.
// Ports:
//   i_clock     system clock, rising edge
//   i_reset     synchronous active-high reset
//   i_tick      one-cycle baud tick at 16x the bit rate
//   i_tx_start  send request, sampled only while idle
//   i_data      word to send, captured when the request is accepted
//   o_tx        registered serial line, idles high
//   o_tx_done   one-cycle pulse at the end of the stop period
//   o_busy      high while a frame is in progress
module uart_tx #(
   parameter int NB_DATA = 8,
   parameter int SB_TICK = 16
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_tick,
   input  logic               i_tx_start,
   input  logic [NB_DATA-1:0] i_data,
   output logic               o_tx,
   output logic               o_tx_done,
   output logic               o_busy
);

   // Tick counter must hold both 15 and SB_TICK-1.
   localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
   localparam int NW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

   localparam logic [SW-1:0] S_BIT  = SW'(15);
   localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST = NW'(NB_DATA - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t               r_state;
   state_t               w_state;
   logic [SW-1:0]        r_s;
   logic [SW-1:0]        w_s;
   logic [NW-1:0]        r_n;
   logic [NW-1:0]        w_n;
   logic [NB_DATA-1:0]   r_b;
   logic [NB_DATA-1:0]   w_b;
   logic                 r_tx;
   logic                 w_tx;
   logic                 r_done;
   logic                 w_done;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= IDLE;
         r_s     <= '0;
         r_n     <= '0;
         r_b     <= '0;
         r_tx    <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_s     <= w_s;
         r_n     <= w_n;
         r_b     <= w_b;
         r_tx    <= w_tx;
         r_done  <= w_done;
      end
   end

   always_comb begin
      w_state = r_state;
      w_s     = r_s;
      w_n     = r_n;
      w_b     = r_b;
      w_done  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (i_tx_start) begin
               w_b     = i_data;
               w_s     = '0;
               w_state = START;
            end
         end
         START: begin
            if (i_tick) begin
               if (r_s == S_BIT) begin
                  w_s     = '0;
                  w_n     = '0;
                  w_state = DATA;
               end else begin
                  w_s = r_s + 1'b1;
               end
            end
         end
         DATA: begin
            if (i_tick) begin
               if (r_s == S_BIT) begin
                  w_s = '0;
                  w_b = r_b >> 1;
                  if (r_n == N_LAST) begin
                     w_state = STOP;
                  end else begin
                     w_n = r_n + 1'b1;
                  end
               end else begin
                  w_s = r_s + 1'b1;
               end
            end
         end
         STOP: begin
            if (i_tick) begin
               if (r_s == S_STOP) begin
                  w_state = IDLE;
                  w_done  = 1'b1;
               end else begin
                  w_s = r_s + 1'b1;
               end
            end
         end
         default: begin
            w_state = IDLE;
         end
      endcase
   end

   // Line level is derived from the next state so o_tx can be a flop
   // and still change on the same edge as the state.
   always_comb begin
      w_tx = 1'b1;
      unique case (w_state)
         START:   w_tx = 1'b0;
         DATA:    w_tx = w_b[0];
         default: w_tx = 1'b1;
      endcase
   end

   assign o_tx      = r_tx;
   assign o_tx_done = r_done;
   assign o_busy    = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx (default and 2-stop-bit).
// Drives inputs after edges, samples outputs on the falling edge.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick;
   logic       start;
   logic       sel;
   logic [7:0] data;
   logic       tx0, tx1, done0, done1, busy0, busy1;
   logic       m_tx, m_done, m_busy;

   int checks = 0;
   int errors = 0;
   int tick_per = 4;
   int tcnt = 0;
   logic smp [10];

   always #5 clk = ~clk;

   uart_tx u0 (
      .i_clock(clk), .i_reset(rst), .i_tick(tick),
      .i_tx_start(start & ~sel), .i_data(data),
      .o_tx(tx0), .o_tx_done(done0), .o_busy(busy0)
   );

   uart_tx #(.SB_TICK(32)) u1 (
      .i_clock(clk), .i_reset(rst), .i_tick(tick),
      .i_tx_start(start & sel), .i_data(data),
      .o_tx(tx1), .o_tx_done(done1), .o_busy(busy1)
   );

   assign m_tx   = sel ? tx1 : tx0;
   assign m_done = sel ? done1 : done0;
   assign m_busy = sel ? busy1 : busy0;

   // Baud tick: periodic when tick_per > 0, otherwise random ~1/3 duty.
   initial begin
      tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (tick_per == 0) begin
            tick = ($urandom_range(0, 2) == 0);
         end else begin
            tcnt = (tcnt + 1) % tick_per;
            tick = (tcnt == 0);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference line level k ticks after the start bit began.
   function automatic logic expbit(input logic [7:0] d, input int k);
      if (k < 16) return 1'b0;
      if (k < 16 * 9) return d[(k - 16) / 16];
      return 1'b1;
   endfunction

   task automatic run_frame(input bit s1, input logic [7:0] d,
                            input bit pre, input bit hold,
                            input logic [7:0] nxt, input bit intrude,
                            input int abort_at);
      int k, cyc, tot;
      bit fin, did;
      tot = 16 * 9 + (s1 ? 32 : 16);
      sel = s1;
      for (int j = 0; j < 10; j++) smp[j] = 1'bx;
      if (!pre) begin
         @(negedge clk);
         start = 1'b1;
         data  = d;
      end
      k = 0; cyc = 0; fin = 0; did = 0;
      while (!fin) begin
         @(negedge clk);
         cyc++;
         if (!hold) begin
            start = 1'b0;
            data  = 8'($urandom);
         end
         if (intrude && !did && k == 80) begin
            start = 1'b1;
            data  = 8'hFF;
            did   = 1;
         end
         if (abort_at > 0 && k == abort_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("abort_tx", 32'(m_tx), 1);
            chk("abort_busy", 32'(m_busy), 0);
            chk("abort_done", 32'(m_done), 0);
            repeat (20) begin
               @(negedge clk);
               chk("abort_quiet", {m_done, m_busy, m_tx}, 3'b001);
            end
            return;
         end
         if (m_done === 1'b1) begin
            fin = 1;
            chk("frame_len", k, tot);
            chk("done_busy", 32'(m_busy), 0);
            chk("done_tx", 32'(m_tx), 1);
            if (hold) data = nxt;
         end else if (cyc > 4000) begin
            fin = 1;
            chk("done_timeout", 32'(m_done), 1);
         end else begin
            chk("busy", 32'(m_busy), 1);
            chk("tx", 32'(m_tx), 32'(expbit(d, k)));
            if (tick) begin
               if (k % 16 == 8 && k < 160) smp[k / 16] = m_tx;
               k++;
            end
         end
      end
      if (!hold) begin
         @(negedge clk);
         chk("post_idle", {m_done, m_busy, m_tx}, 3'b001);
      end
   endtask

   typedef struct {
      bit         s1;
      logic [7:0] d;
      int         per;
      bit         intrude;
      logic [9:0] pat;
   } vec_t;

   vec_t tbl [6];

   initial begin
      tbl[0] = '{0, 8'hA5, 4, 0, 10'b1101001010};
      tbl[1] = '{0, 8'h3C, 3, 1, {1'b1, 8'h3C, 1'b0}};
      tbl[2] = '{1, 8'h81, 2, 0, {1'b1, 8'h81, 1'b0}};
      tbl[3] = '{0, 8'h00, 1, 0, {1'b1, 8'h00, 1'b0}};
      tbl[4] = '{0, 8'hFF, 0, 0, {1'b1, 8'hFF, 1'b0}};
      tbl[5] = '{1, 8'h5A, 0, 1, {1'b1, 8'h5A, 1'b0}};

      rst = 1'b1; sel = 1'b0; start = 1'b0; data = 8'h00;
      repeat (3) begin
         start = 1'($urandom);
         data  = 8'($urandom);
         @(negedge clk);
         chk("rst_u0", {done0, busy0, tx0}, 3'b001);
         chk("rst_u1", {done1, busy1, tx1}, 3'b001);
      end
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("rel_u0", {done0, busy0, tx0}, 3'b001);
      chk("rel_u1", {done1, busy1, tx1}, 3'b001);

      for (int i = 0; i < 6; i++) begin
         tick_per = tbl[i].per;
         run_frame(tbl[i].s1, tbl[i].d, 0, 0, 8'h00, tbl[i].intrude, 0);
         for (int j = 0; j < 10; j++)
            chk($sformatf("mid%0d_bit%0d", i, j), 32'(smp[j]),
                32'(tbl[i].pat[j]));
      end

      // Back-to-back: request held high across both frames.
      tick_per = 2;
      run_frame(0, 8'h00, 0, 1, 8'hFF, 0, 0);
      run_frame(0, 8'hFF, 1, 0, 8'h00, 0, 0);

      // Reset during the third data bit, then a clean frame.
      tick_per = 3;
      run_frame(0, 8'h55, 0, 0, 8'h00, 0, 56);
      run_frame(0, 8'h0F, 0, 0, 8'h00, 0, 0);
      for (int j = 0; j < 10; j++)
         chk($sformatf("f0F_bit%0d", j), 32'(smp[j]),
             32'(expbit(8'h0F, 16 * j + 8)));

      for (int i = 0; i < 16; i++) begin
         tick_per = $urandom_range(0, 4);
         run_frame(1'($urandom), 8'($urandom), 0, 0, 8'h00,
                   1'($urandom), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the board's UART link: accepts an 8-bit word in parallel and shifts it out as one 8N1 frame (start bit, 8 data bits LSB first, stop bit), timed by an external 16x-oversampled baud tick. It is the sending end of the link and returns ALU results to the host PC. The ALU result feeds `i_data`, and a control FSM pulses `i_tx_start`. It shares the baud-rate tick generator with the receive side.

## Interface
- `NB_DATA`, default 8: data bits per frame.
- `SB_TICK`, default 16: baud ticks spent in the stop state (16 gives 1 stop bit, 24 gives 1.5, 32 gives 2).
- `i_clock`, input, 1 bit: system clock. All logic is on the rising edge.
- `i_reset`, input, 1 bit: reset. Synchronous and active-high.
- `i_tick`, input, 1 bit: baud tick, one-cycle pulse at 16x the baud rate.
- `i_tx_start`, input, 1 bit: request to send `i_data`. Sampled only in IDLE.
- `i_data`, input, `NB_DATA` bits: word to transmit. Captured on the accepting edge.
- `o_tx`, output, 1 bit: serial line. Idles high.
- `o_tx_done`, output, 1 bit: one-cycle pulse when the frame's stop period ends.
- `o_busy`, output, 1 bit: high whenever state is not IDLE.

## Operation
- Registers:
  - state: IDLE, START, DATA, STOP.
  - tick counter `s`: 4 bits, wide enough for `SB_TICK-1`.
  - bit counter `n`: `clog2(NB_DATA)` bits.
  - shift register `b`: `NB_DATA` bits.
  - `tx_reg`, which drives `o_tx`.
- Reset, while `i_reset` is high at an edge:
  - state goes to IDLE; `s`, `n` and `b` clear to 0.
  - `o_tx`=1, `o_tx_done`=0, `o_busy`=0.
  - Reset mid-frame aborts the frame immediately; no done pulse is generated.
- IDLE:
  - `o_tx`=1.
  - If `i_tx_start`=1: `b` <= `i_data`, `s` <= 0, go to START. `i_tick` is not required for this.
- START:
  - `o_tx`=0.
  - On each `i_tick`: if `s`==15 then `s` <= 0, `n` <= 0, go to DATA; otherwise `s` <= `s`+1.
- DATA:
  - `o_tx` = `b[0]`.
  - On each `i_tick`, when `s`==15:
    - `s` <= 0 and `b` <= `b` >> 1.
    - If `n`==`NB_DATA`-1, go to STOP; otherwise `n` <= `n`+1.
  - On other ticks, `s` increments.
- STOP:
  - `o_tx`=1.
  - On each `i_tick`: if `s`==`SB_TICK`-1, go to IDLE and assert `o_tx_done` for exactly one cycle; otherwise `s` <= `s`+1.
- `i_tx_start` outside IDLE is ignored. There is no queueing, and `i_data` changes while busy have no effect.
- Counters never wrap inside a state: every exit condition is an equality compare that is checked before the increment.
- `o_tx` is registered, so it is glitch-free.

## Timing
- Start is accepted on edge E. `o_tx` falls and `o_busy` rises after edge E, i.e. visible in cycle E+1.
- Each start and data bit lasts exactly 16 `i_tick` pulses. The stop bit lasts `SB_TICK` ticks.
- A full frame is 16·(1+`NB_DATA`)+`SB_TICK` ticks, which is 160 ticks at the defaults.
- `o_tx_done` and the fall of `o_busy` occur on the same edge as the final stop tick.
- Back-to-back frames: if `i_tx_start` is high in the first IDLE cycle after `o_tx_done`, the next start bit begins on that cycle's edge. The minimum gap between frames is therefore the stop period plus 1 clock.
- The FSM acts only on cycles where `i_tick`=1, except for the IDLE to START transition.
- `i_tick` high in the same cycle as start acceptance is not counted toward START.

## Test plan
- **Reset values:** hold `i_reset` high for 3 cycles with random inputs. Require `o_tx`=1, `o_busy`=0 and `o_tx_done`=0 during reset and after release.
- **Single frame, 0xA5:** `i_tick` every 4 clocks; pulse `i_tx_start` with `i_data`=0xA5. Sampling `o_tx` at the middle of each 16-tick bit must give 0,1,0,1,0,0,1,0,1,1. `o_tx_done` must pulse exactly once, 160 ticks after the start bit begins.
- **Start while busy:** send 0x3C. Midway through the frame, pulse `i_tx_start` with `i_data`=0xFF. The line must carry only 0x3C, and there must be exactly one `o_tx_done`.
- **Back-to-back:** hold `i_tx_start` high with 0x00 and then 0xFF. Require two frames separated only by the stop bit plus at most 1 clock, and two done pulses.
- **Reset mid-frame:** assert `i_reset` during the third data bit of 0x55. On the next edge require `o_tx`=1 and `o_busy`=0, and no done pulse. A new 0x0F frame must then transmit correctly.
- **`SB_TICK`=32:** send 0x81. The stop high period must measure 32 ticks, for a total frame length of 176 ticks.
